prbs7_word_checker: RTL

//  Self-synchronising PRBS7 (x^7+x^6+1) checker for 32-bit words, LSB = earliest bit.

---
 rtl/prbs7_word_checker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/prbs7_word_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker for 32-bit LSB-first words with lock FSM and saturating counters.
// Optional inverted-stream detection is enabled by defining PRBS7_CHK_POLARITY_EN.
module prbs7_word_checker #(
  parameter int LOCK_WORDS   = 16,
  parameter int UNLOCK_WORDS = 4,
  parameter int ERRCNT_W     = 32,
  parameter int WCNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         din,
  input  logic                din_valid,
  input  logic                clear,
  output logic                locked,
  output logic                err_word,
  output logic [5:0]          err_bits,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [WCNT_W-1:0]   word_count
`ifdef PRBS7_CHK_POLARITY_EN
  ,
  output logic                polarity_inv
`endif
);

  localparam int GC_W = $clog2(LOCK_WORDS + 1);
  localparam int BC_W = $clog2(UNLOCK_WORDS + 1);

  typedef enum logic [1:0] {PRIME, HUNT, LOCKED} state_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  logic [6:0]  hist;
  logic [38:0] ext;
  logic [31:0] mis;
  logic [31:0] a_mis;
  logic        a_zero;
  logic        a_valid;
`ifdef PRBS7_CHK_POLARITY_EN
  logic        a_ones;
  logic        pol, pol_nx, pinv_nx;
  logic        clean_p, clean_o;
`else
  logic        clean_n;
`endif

  // Each bit must equal the XOR of the bits 7 and 6 positions earlier in the stream.
  assign ext = {din, hist};
  assign mis = din ^ ext[32:1] ^ ext[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      a_mis   <= '0;
      a_zero  <= 1'b0;
      a_valid <= 1'b0;
`ifdef PRBS7_CHK_POLARITY_EN
      a_ones  <= 1'b0;
`endif
    end else begin
      a_valid <= din_valid;
      if (din_valid) begin
        hist   <= din[31:25];
        a_mis  <= mis;
        a_zero <= (din == '0);
`ifdef PRBS7_CHK_POLARITY_EN
        a_ones <= (&din);
`endif
      end
    end
  end

  state_t              state, state_nx;
  logic [GC_W-1:0]     good_cnt, good_nx;
  logic [BC_W-1:0]     bad_cnt, bad_nx;
  logic                ew_nx;
  logic [5:0]          eb_nx;
  logic [ERRCNT_W-1:0] ec_nx;
  logic [WCNT_W-1:0]   wc_nx;
  logic [31:0]         eff_mis;
  logic                guard;
  logic                errored;
  logic [5:0]          bits;
  logic [ERRCNT_W:0]   ec_sum;

`ifdef PRBS7_CHK_POLARITY_EN
  // An inverted stream mismatches everywhere, and all-ones is its stuck-value guard.
  assign eff_mis = pol ? ~a_mis : a_mis;
  assign guard   = pol ? a_ones : a_zero;
  assign clean_p = pol ? ((&a_mis) && !a_ones) : ((a_mis == '0) && !a_zero);
  assign clean_o = pol ? ((a_mis == '0) && !a_zero) : ((&a_mis) && !a_ones);
`else
  assign eff_mis = a_mis;
  assign guard   = a_zero;
  assign clean_n = (a_mis == '0) && !a_zero;
`endif

  assign errored = (eff_mis != '0) || guard;
  assign bits    = guard ? 6'd32 : popcount(eff_mis);
  assign ec_sum  = {1'b0, err_count} + {{(ERRCNT_W-5){1'b0}}, bits};
  assign locked  = (state == LOCKED);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    ew_nx    = 1'b0;
    eb_nx    = '0;
    ec_nx    = err_count;
    wc_nx    = word_count;
`ifdef PRBS7_CHK_POLARITY_EN
    pol_nx   = pol;
    pinv_nx  = polarity_inv;
`endif
    if (a_valid) begin
      unique case (state)
        PRIME: begin
          state_nx = HUNT;
          good_nx  = '0;
        end
        HUNT: begin
`ifdef PRBS7_CHK_POLARITY_EN
          if (clean_p) begin
            good_nx = good_cnt + GC_W'(1);
          end else if (clean_o) begin
            pol_nx  = ~pol;
            good_nx = GC_W'(1);
          end else begin
            good_nx = '0;
          end
`else
          good_nx = clean_n ? good_cnt + GC_W'(1) : '0;
`endif
          if (good_nx == GC_W'(LOCK_WORDS)) begin
            state_nx = LOCKED;
            bad_nx   = '0;
`ifdef PRBS7_CHK_POLARITY_EN
            pinv_nx  = pol_nx;
`endif
          end
        end
        LOCKED: begin
          wc_nx = (&word_count) ? word_count : word_count + WCNT_W'(1);
          if (errored) begin
            ew_nx  = 1'b1;
            eb_nx  = bits;
            ec_nx  = ec_sum[ERRCNT_W] ? '1 : ec_sum[ERRCNT_W-1:0];
            bad_nx = bad_cnt + BC_W'(1);
            if (bad_nx == BC_W'(UNLOCK_WORDS)) begin
              state_nx = HUNT;
              good_nx  = '0;
            end
          end else begin
            bad_nx = '0;
          end
        end
        default: state_nx = PRIME;
      endcase
    end
    if (clear) begin
      ec_nx = '0;
      wc_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PRIME;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      err_word   <= 1'b0;
      err_bits   <= '0;
      err_count  <= '0;
      word_count <= '0;
`ifdef PRBS7_CHK_POLARITY_EN
      pol          <= 1'b0;
      polarity_inv <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      good_cnt   <= good_nx;
      bad_cnt    <= bad_nx;
      err_word   <= ew_nx;
      err_bits   <= eb_nx;
      err_count  <= ec_nx;
      word_count <= wc_nx;
`ifdef PRBS7_CHK_POLARITY_EN
      pol          <= pol_nx;
      polarity_inv <= pinv_nx;
`endif
    end
  end

endmodule
